// File: rtl/preproc_seq_pkg.sv
// Shared types and constants for the PPG pre-processing sequencer.
// Holds the FSM state type, default timing constants and a counter-width helper.
package preproc_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StRun
    } seq_state_e;

    localparam int unsigned DefClkDiv = 1000;
    localparam int unsigned DefSettle = 64;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/preproc_strobe_gen.sv
// Sample-rate strobe for the pre-processing chain: one-cycle pp_en every CLK_DIV cycles
// while run is high; the count restarts from zero whenever run drops.
module preproc_strobe_gen
    import preproc_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefClkDiv
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic pp_en
);

    localparam int unsigned DW = cnt_width(CLK_DIV - 1);
    localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DivPreLast = DW'(CLK_DIV - 2);

    logic [DW-1:0] div_cnt;

    // pp_en is decoded one count early so the registered pulse lines up with div_cnt == last.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_cnt <= '0;
            pp_en   <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DivLast) ? '0 : div_cnt + 1'b1;
            pp_en   <= (div_cnt == DivPreLast);
        end
    end

endmodule

// File: rtl/preproc_sequencer.sv
// Controller for the PPG pre-processing chain: start/stop FSM, filter settling discard,
// and a single-entry valid/ready output register with sticky overrun flag.
module preproc_sequencer
    import preproc_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned CLK_DIV = DefClkDiv,
    parameter int unsigned SETTLE  = DefSettle
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    output logic                    pp_en,
    input  logic signed [WIDTH-1:0] pp_data,
    input  logic                    pp_valid,
    output logic signed [WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy,
    output logic                    settled,
    output logic                    overrun
);

    localparam int unsigned SW = cnt_width(SETTLE);
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE - 1);

    seq_state_e    state;
    logic [SW-1:0] settle_cnt;
    logic          run;

    // Drop run in the stop cycle itself so no strobe is issued once we head to idle.
    assign run = (state != StIdle) && !stop;

    preproc_strobe_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_strobe_gen (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .pp_en (pp_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            busy       <= 1'b0;
            settled    <= 1'b0;
            settle_cnt <= '0;
            overrun    <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start && !stop) begin
                        state      <= StWarmup;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                        overrun    <= 1'b0;
                    end
                end
                StWarmup: begin
                    if (stop) begin
                        state   <= StIdle;
                        busy    <= 1'b0;
                        settled <= 1'b0;
                    end else if (pp_valid) begin
                        settle_cnt <= settle_cnt + 1'b1;
                        if (settle_cnt == SettleLast) begin
                            state   <= StRun;
                            settled <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (stop) begin
                        state   <= StIdle;
                        busy    <= 1'b0;
                        settled <= 1'b0;
                    end
                end
                default: begin
                    state   <= StIdle;
                    busy    <= 1'b0;
                    settled <= 1'b0;
                end
            endcase

            // A pending sample is never overwritten; it drains even after stop.
            if (state == StRun && pp_valid) begin
                if (!m_valid || m_ready) begin
                    m_data  <= pp_data;
                    m_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_preproc_sequencer.sv
// Self-checking bench for preproc_sequencer: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_preproc_sequencer;

    localparam int W       = 10;
    localparam int CLK_DIV = 4;
    localparam int SETTLE  = 3;

    logic                clk = 1'b0;
    logic                rst, start, stop, pp_valid, m_ready;
    logic signed [W-1:0] pp_data;
    logic                pp_en, m_valid, busy, settled, overrun;
    logic signed [W-1:0] m_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    preproc_sequencer #(
        .WIDTH   (W),
        .CLK_DIV (CLK_DIV),
        .SETTLE  (SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pp_en    (pp_en),
        .pp_data  (pp_data),
        .pp_valid (pp_valid),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .settled  (settled),
        .overrun  (overrun)
    );

    // Behavioural model: mode 0 idle, 1 warming up, 2 running; age counts cycles since start.
    int                  md_mode, md_age, md_settle;
    bit                  md_ovr, md_en;
    logic signed [W-1:0] md_q[$];
    logic signed [W-1:0] md_last;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        md_mode = 0; md_age = 0; md_settle = 0; md_ovr = 0; md_en = 0;
        md_q.delete();
        md_last = '0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit p, input bit v,
                              input logic signed [W-1:0] d, input bit rd);
        int cur, nxt;
        if (r) begin
            model_reset();
            return;
        end
        cur = md_mode;
        nxt = cur;
        if (cur == 0 && s && !p) begin
            nxt = 1; md_settle = 0; md_ovr = 0; md_age = 0;
        end else if (cur != 0 && p) begin
            nxt = 0;
        end else if (cur != 0) begin
            md_age++;
        end
        if (cur == 1 && !p && v) begin
            md_settle++;
            if (md_settle == SETTLE) nxt = 2;
        end
        if (cur == 2 && v) begin
            if (md_q.size() == 0 || rd) begin
                md_q.delete();
                md_q.push_back(d);
                md_last = d;
            end else begin
                md_ovr = 1;
            end
        end else if (md_q.size() != 0 && rd) begin
            md_q.delete();
        end
        md_mode = nxt;
        md_en = (nxt != 0) && (md_age % CLK_DIV == CLK_DIV - 1);
    endtask

    // Apply one cycle of inputs, clock it, then compare every output with the model.
    task automatic tick(input bit r, input bit s, input bit p, input bit v, input int d,
                        input bit rd);
        logic signed [W-1:0] dv;
        dv = W'(d);
        rst = r; start = s; stop = p; pp_valid = v; pp_data = dv; m_ready = rd;
        @(posedge clk);
        #1;
        model_step(r, s, p, v, dv, rd);
        chk("model pp_en", int'(pp_en), int'(md_en));
        chk("model busy", int'(busy), int'(md_mode != 0));
        chk("model settled", int'(settled), int'(md_mode == 2));
        chk("model m_valid", int'(m_valid), int'(md_q.size() != 0));
        chk("model m_data", int'(m_data), int'(md_last));
        chk("model overrun", int'(overrun), int'(md_ovr));
    endtask

    typedef struct {
        bit r, s, p, v; int d; bit rd;
        bit e_busy, e_set, e_en, e_mv; int e_md; bit e_ovr;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit p, bit v, int d, bit rd,
                                bit b, bit st, bit en, bit mv, int md, bit ov);
        vec_t t;
        t.r = r; t.s = s; t.p = p; t.v = v; t.d = d; t.rd = rd;
        t.e_busy = b; t.e_set = st; t.e_en = en; t.e_mv = mv; t.e_md = md; t.e_ovr = ov;
        return t;
    endfunction

    vec_t vecs[$];

    initial begin
        model_reset();
        rst = 1; start = 0; stop = 0; pp_valid = 0; pp_data = '0; m_ready = 0;

        // Rows: inputs during a cycle, expected outputs in the following cycle.
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,0, 0,0));  // reset
        vecs.push_back(mk(0,1,0,0, 0,0, 1,0,0,0, 0,0));  // start at cycle 0
        vecs.push_back(mk(0,0,0,0, 0,0, 1,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,0,1,0, 0,0));  // pp_en at cycle 4
        vecs.push_back(mk(0,0,0,1,10,0, 1,0,0,0, 0,0));  // discarded
        vecs.push_back(mk(0,0,0,0, 0,0, 1,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,0,1,0, 0,0));  // cycle 8
        vecs.push_back(mk(0,0,0,1,11,0, 1,0,0,0, 0,0));  // discarded
        vecs.push_back(mk(0,0,0,0, 0,0, 1,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,0,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,0,1,0, 0,0));  // cycle 12
        vecs.push_back(mk(0,0,0,1,12,0, 1,1,0,0, 0,0));  // third sample settles
        vecs.push_back(mk(0,0,0,0, 0,0, 1,1,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,1,0,0, 0,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,1,1,0, 0,0));  // cycle 16
        vecs.push_back(mk(0,0,0,1,13,1, 1,1,0,1,13,0));  // first output sample
        vecs.push_back(mk(0,0,0,0, 0,1, 1,1,0,0,13,0));  // accepted, one-cycle valid
        vecs.push_back(mk(0,0,0,0, 0,0, 1,1,0,0,13,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,1,1,0,13,0));  // cycle 20
        vecs.push_back(mk(0,0,0,1,20,0, 1,1,0,1,20,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,1,0,1,20,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,1,0,1,20,0));
        vecs.push_back(mk(0,0,0,0, 0,0, 1,1,1,1,20,0));  // cycle 24
        vecs.push_back(mk(0,0,0,1,21,0, 1,1,0,1,20,1));  // 21 dropped
        vecs.push_back(mk(0,0,0,0, 0,1, 1,1,0,0,20,1));  // 20 accepted

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].v, vecs[i].d, vecs[i].rd);
            chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].e_busy));
            chk($sformatf("vec%0d settled", i), int'(settled), int'(vecs[i].e_set));
            chk($sformatf("vec%0d pp_en", i), int'(pp_en), int'(vecs[i].e_en));
            chk($sformatf("vec%0d m_valid", i), int'(m_valid), int'(vecs[i].e_mv));
            chk($sformatf("vec%0d m_data", i), int'(m_data), vecs[i].e_md);
            chk($sformatf("vec%0d overrun", i), int'(overrun), int'(vecs[i].e_ovr));
        end

        // Stop in RUN with a pending sample: strobes cease, sample still drains.
        tick(0,0,0,1,30,0);
        chk("pend m_data", int'(m_data), 30);
        tick(0,0,1,0,0,0);
        chk("stop busy", int'(busy), 0);
        chk("stop settled", int'(settled), 0);
        chk("stop pp_en", int'(pp_en), 0);
        chk("stop keeps m_valid", int'(m_valid), 1);
        for (int i = 0; i < 2 * CLK_DIV; i++) begin
            tick(0,0,0,0,0,0);
            chk("idle pp_en", int'(pp_en), 0);
        end
        tick(0,0,0,0,0,1);
        chk("drain after stop", int'(m_valid), 0);

        // Simultaneous start and stop in IDLE: stop wins.
        tick(0,1,1,0,0,0);
        chk("start+stop busy", int'(busy), 0);
        tick(0,0,0,1,5,0);
        chk("idle ignores pp_valid", int'(m_valid), 0);

        // Restart clears overrun; then back-to-back load while draining.
        tick(0,1,0,0,0,0);
        chk("restart clears overrun", int'(overrun), 0);
        for (int i = 0; i < SETTLE; i++) tick(0,0,0,1,int'($urandom_range(0, 511)),0);
        chk("resettled", int'(settled), 1);
        chk("warmup no output", int'(m_valid), 0);
        tick(0,0,0,1,30,0);
        tick(0,0,0,1,31,1);
        chk("drain+load m_data", int'(m_data), 31);
        chk("drain+load m_valid", int'(m_valid), 1);
        chk("drain+load overrun", int'(overrun), 0);

        // Reset mid-RUN with a pending sample, then full warmup again.
        tick(0,0,0,0,0,0);
        tick(1,0,0,0,0,0);
        chk("rst busy", int'(busy), 0);
        chk("rst m_valid", int'(m_valid), 0);
        chk("rst m_data", int'(m_data), 0);
        chk("rst pp_en", int'(pp_en), 0);
        tick(0,1,0,0,0,0);
        for (int i = 0; i < SETTLE - 1; i++) tick(0,0,0,1,7,0);
        chk("rewarm not settled", int'(settled), 0);
        tick(0,0,0,1,7,0);
        chk("rewarm settled", int'(settled), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 1023)), ($urandom_range(0, 1) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
